selectn_wait: RTL and testbench

- Parametrised multi-channel programmable chip-select with per-channel wait-state generation, sitting between the CPU bus and the memory/peripheral decode.
- Each channel holds CPU-writable mask, compare and control registers. The block matches the bus address against every enabled channel and latches the lowest-numbered hit for the whole bus cycle.
- It drives a one-hot select, then asserts ready after the programmed number of wait states.

---
 rtl/selectn_pkg.sv | 27 ++
 rtl/selectn_wait_if.sv | 32 +++
 rtl/selectn_chan.sv | 74 +++++++
 rtl/selectn_wait.sv | 165 ++++++++++++++++
 tb/tb_selectn_wait.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/selectn_pkg.sv
// Shared types and constants for the selectn_wait chip-select block.
package selectn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OFS_CTRL = 2'd0;
    localparam logic [1:0] OFS_MASK = 2'd1;
    localparam logic [1:0] OFS_COMP = 2'd2;
    localparam logic [1:0] OFS_STAT = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IO       = 1;
    localparam int CTRL_WAIT_LSB = 2;

    localparam int STAT_MISS = 7;
    localparam int STAT_CONF = 6;

    // Channel-index width; a single channel still needs one bit of index.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/selectn_wait_if.sv
// Bus-side bundle of selectn_wait: decode address, strobe, CPU register port and select outputs.
interface selectn_wait_if
    import selectn_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8
) ();
    localparam int CHW = chan_idx_w(CHANNELS);

    logic [ADDR_W-1:0]   addr;
    logic                strobe;
    logic [CHW+1:0]      reg_addr;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic                data_oe;
    logic                write;
    logic                read;
    logic                selectin;
    logic [CHANNELS-1:0] selectout;
    logic                ready;

    modport master (
        output addr, strobe, reg_addr, data_in, write, read, selectin,
        input  data_out, data_oe, selectout, ready
    );

    modport slave (
        input  addr, strobe, reg_addr, data_in, write, read, selectin,
        output data_out, data_oe, selectout, ready
    );
endinterface

// File: rtl/selectn_chan.sv
// One select channel: control/mask/compare registers, address-field match and register read data.
// SELECTN_READBACK_EN enables readback of offsets 0-2; otherwise they read as zero.
module selectn_chan
    import selectn_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MATCH_W = 6,
    parameter int WAIT_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_wr,
    input  logic [1:0]         i_ofs,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               o_hit,
    output logic [WAIT_W-1:0]  o_wait,
    output logic [DATA_W-1:0]  o_rdata
);
    logic               r_en;
    logic               r_io;
    logic [WAIT_W-1:0]  r_wait;
    logic [MATCH_W-1:0] r_mask;
    logic [MATCH_W-1:0] r_comp;
    logic [MATCH_W-1:0] w_field;
    logic               w_unused;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_io   <= 1'b0;
            r_wait <= '0;
            r_mask <= '0;
            r_comp <= '0;
        end else if (i_wr) begin
            case (i_ofs)
                OFS_CTRL: begin
                    r_en   <= i_data[CTRL_EN];
                    r_io   <= i_data[CTRL_IO];
                    r_wait <= i_data[CTRL_WAIT_LSB +: WAIT_W];
                end
                OFS_MASK: r_mask <= i_data[MATCH_W-1:0];
                OFS_COMP: r_comp <= i_data[MATCH_W-1:0];
                default:  ;
            endcase
        end
    end

    // io channels decode the low address field (above the byte lane bits), memory channels the top bits
    assign w_field = r_io ? i_addr[MATCH_W+1:2] : i_addr[ADDR_W-1:ADDR_W-MATCH_W];
    assign o_hit   = r_en && ((w_field & r_mask) == r_comp);
    assign o_wait  = r_wait;

`ifdef SELECTN_READBACK_EN
    always_comb begin
        o_rdata = '0;
        case (i_ofs)
            OFS_CTRL: begin
                o_rdata[CTRL_EN]                  = r_en;
                o_rdata[CTRL_IO]                  = r_io;
                o_rdata[CTRL_WAIT_LSB +: WAIT_W]  = r_wait;
            end
            OFS_MASK: o_rdata[MATCH_W-1:0] = r_mask;
            OFS_COMP: o_rdata[MATCH_W-1:0] = r_comp;
            default:  o_rdata = '0;
        endcase
    end
`else
    assign o_rdata = '0;
`endif

    assign w_unused = ^{i_addr, i_data};
endmodule

// File: rtl/selectn_wait.sv
// Programmable multi-channel chip select with per-channel wait states.
// Build option SELECTN_READBACK_EN (in selectn_chan) makes offsets 0-2 readable.
module selectn_wait
    import selectn_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MATCH_W  = 6,
    parameter int WAIT_W   = 3
) (
    input  logic          clock,
    input  logic          reset,
    selectn_wait_if.slave bus
);
    localparam int CHW   = chan_idx_w(CHANNELS);
    localparam int NSLOT = 1 << CHW;

    logic [CHW-1:0]      w_ch;
    logic [1:0]          w_ofs;
    logic                w_wr;
    logic                w_rd;
    logic                w_stat_rd;
    logic [CHANNELS-1:0] w_hit;
    logic [WAIT_W-1:0]   w_wait  [CHANNELS];
    logic [DATA_W-1:0]   w_rdata [NSLOT];
    logic                w_found;
    logic                w_multi;
    logic [CHW-1:0]      w_win;
    logic                w_start;

    state_e              r_state, w_state_nxt;
    logic [WAIT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CHANNELS-1:0] r_sel, w_sel_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_miss, r_conf;
    logic [CHW-1:0]      r_last;
    logic [DATA_W-1:0]   w_dout;
    logic                w_oe;

    assign w_ch      = bus.reg_addr[CHW+1:2];
    assign w_ofs     = bus.reg_addr[1:0];
    assign w_wr      = bus.write && bus.selectin;
    assign w_rd      = bus.read && bus.selectin;
    assign w_stat_rd = w_rd && (w_ofs == OFS_STAT);

    // Slots beyond CHANNELS (non power-of-two counts) read as zero and ignore writes
    for (genvar g = 0; g < NSLOT; g++) begin : g_chan
        if (g < CHANNELS) begin : g_inst
            selectn_chan #(
                .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MATCH_W(MATCH_W), .WAIT_W(WAIT_W)
            ) u_chan (
                .clock  (clock),
                .reset  (reset),
                .i_wr   (w_wr && (w_ch == CHW'(g))),
                .i_ofs  (w_ofs),
                .i_data (bus.data_in),
                .i_addr (bus.addr),
                .o_hit  (w_hit[g]),
                .o_wait (w_wait[g]),
                .o_rdata(w_rdata[g])
            );
        end else begin : g_pad
            assign w_rdata[g] = '0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_found = 1'b1;
                w_win   = CHW'(i);
            end
        end
    end

    assign w_multi = |(w_hit & (w_hit - CHANNELS'(1)));
    assign w_start = (r_state == ST_IDLE) && bus.strobe;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.strobe)
                         w_state_nxt = (w_found && (w_wait[w_win] != '0)) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (!bus.strobe)              w_state_nxt = ST_IDLE;
                     else if (r_cnt == WAIT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE: if (!bus.strobe)              w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ready is registered from DONE, so it trails the DONE entry by one cycle
    always_comb begin
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel_nxt = '0;
                if (bus.strobe && w_found) begin
                    w_sel_nxt = CHANNELS'(1) << w_win;
                    w_cnt_nxt = w_wait[w_win];
                end
            end
            ST_WAIT: begin
                if (!bus.strobe) w_sel_nxt = '0;
                else             w_cnt_nxt = r_cnt - WAIT_W'(1);
            end
            ST_DONE: begin
                if (!bus.strobe) w_sel_nxt = '0;
                else             w_ready_nxt = 1'b1;
            end
            default: w_sel_nxt = '0;
        endcase
    end

    // A set event on the clearing edge wins over the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_miss <= 1'b0;
            r_conf <= 1'b0;
            r_last <= '0;
        end else begin
            r_miss <= (w_start && !w_found) || (r_miss && !w_stat_rd);
            r_conf <= (w_start && w_multi)  || (r_conf && !w_stat_rd);
            if (w_start && w_found) r_last <= w_win;
        end
    end

    always_comb begin
        w_dout = '0;
        w_oe   = 1'b0;
        if (w_rd) begin
            w_oe = 1'b1;
            if (w_ofs == OFS_STAT) begin
                w_dout[STAT_MISS] = r_miss;
                w_dout[STAT_CONF] = r_conf;
                w_dout[CHW-1:0]   = r_last;
            end else begin
                w_dout = w_rdata[w_ch];
            end
        end
    end

    assign bus.data_out  = w_dout;
    assign bus.data_oe   = w_oe;
    assign bus.selectout = r_sel;
    assign bus.ready     = r_ready;
endmodule

// File: tb/tb_selectn_wait.sv
// Bench for selectn_wait: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_selectn_wait;
    import selectn_pkg::*;

    localparam int CH = 4, AW = 16, DW = 8, MW = 6, WW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    selectn_wait_if #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    selectn_wait #(
        .CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .MATCH_W(MW), .WAIT_W(WW)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: register file, status and the current bus cycle
    bit          m_en [CH];
    bit          m_io [CH];
    bit [WW-1:0] m_wait [CH];
    bit [MW-1:0] m_mask [CH];
    bit [MW-1:0] m_comp [CH];
    bit          m_miss = 0, m_conf = 0;
    bit [1:0]    m_last = 0;
    bit          m_active = 0;
    longint      edge_k = 0;
    longint      m_ready_at = 0;
    bit [CH-1:0] e_sel = 0;
    bit          e_ready = 0;

    function automatic bit [MW-1:0] field(input int i, input logic [AW-1:0] a);
        if (m_io[i]) return MW'((a >> 2) & 16'h003F);
        return MW'(a >> (AW - MW));
    endfunction

    always @(posedge clk) begin : model
        int hits[$];
        bit rd_stat, s_miss, s_conf;
        int c;
        edge_k++;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_en[i] = 0; m_io[i] = 0; m_wait[i] = 0; m_mask[i] = 0; m_comp[i] = 0;
            end
            m_miss = 0; m_conf = 0; m_last = 0; m_active = 0; e_sel = 0; e_ready = 0;
        end else begin
            rd_stat = bus.read && bus.selectin && (bus.reg_addr[1:0] == 2'd3);
            s_miss = 0;
            s_conf = 0;
            if (!m_active && bus.strobe) begin
                hits.delete();
                for (int i = 0; i < CH; i++)
                    if (m_en[i] && ((field(i, bus.addr) & m_mask[i]) == m_comp[i])) hits.push_back(i);
                m_active = 1;
                e_ready  = 0;
                if (hits.size() == 0) begin
                    s_miss = 1;
                    e_sel = 0;
                    m_ready_at = edge_k + 1;
                end else begin
                    e_sel = CH'(1 << hits[0]);
                    m_last = 2'(hits[0]);
                    s_conf = (hits.size() > 1);
                    m_ready_at = edge_k + longint'(m_wait[hits[0]]) + 1;
                end
            end else if (m_active && !bus.strobe) begin
                m_active = 0; e_sel = 0; e_ready = 0;
            end else if (m_active) begin
                e_ready = (edge_k >= m_ready_at);
            end else begin
                e_sel = 0; e_ready = 0;
            end
            m_miss = s_miss | (m_miss & !rd_stat);
            m_conf = s_conf | (m_conf & !rd_stat);
            if (bus.write && bus.selectin) begin
                c = int'(bus.reg_addr[3:2]);
                case (bus.reg_addr[1:0])
                    2'd0: begin
                        m_en[c] = bus.data_in[0];
                        m_io[c] = bus.data_in[1];
                        m_wait[c] = bus.data_in[4:2];
                    end
                    2'd1: m_mask[c] = bus.data_in[5:0];
                    2'd2: m_comp[c] = bus.data_in[5:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [7:0] exp_rd();
        int c;
        if (!(bus.read && bus.selectin)) return 8'h00;
        c = int'(bus.reg_addr[3:2]);
        if (bus.reg_addr[1:0] == 2'd3) return {m_miss, m_conf, 4'b0000, m_last};
`ifdef SELECTN_READBACK_EN
        if (bus.reg_addr[1:0] == 2'd0) return {3'b000, m_wait[c], m_io[c], m_en[c]};
        if (bus.reg_addr[1:0] == 2'd1) return {2'b00, m_mask[c]};
        if (bus.reg_addr[1:0] == 2'd2) return {2'b00, m_comp[c]};
`endif
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("selectout", bus.selectout, e_sel);
            chk("ready", bus.ready, e_ready);
            chk("data_oe", bus.data_oe, bus.read && bus.selectin);
            chk("data_out", bus.data_out, exp_rd());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int c, input int o, input logic [7:0] d);
        bus.reg_addr = 4'(c * 4 + o);
        bus.data_in  = d;
        bus.write    = 1'b1;
        bus.selectin = 1'b1;
        tick();
        bus.write    = 1'b0;
        bus.selectin = 1'b0;
    endtask

    task automatic rd_set(input int c, input int o);
        bus.reg_addr = 4'(c * 4 + o);
        bus.read     = 1'b1;
        bus.selectin = 1'b1;
        #1;
    endtask

    task automatic rd_off();
        bus.read     = 1'b0;
        bus.selectin = 1'b0;
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = 16'($urandom);
        a[15:10] = 6'($urandom_range(0, 3));
        a[7:2]   = 6'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        int hold, gap, op;
        logic [7:0] mopts [4];
        mopts[0] = 8'h3F; mopts[1] = 8'h03; mopts[2] = 8'h00; mopts[3] = 8'h3C;
        bus.addr = '0; bus.strobe = 0; bus.reg_addr = '0; bus.data_in = '0;
        bus.write = 0; bus.read = 0; bus.selectin = 0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1;
        chk("rst_sel", bus.selectout, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_oe", bus.data_oe, 0);
        rst = 1'b0;
        for (int c = 0; c < CH; c++)
            for (int o = 0; o < 4; o++) begin
                rd_set(c, o);
                chk("rst_reg", bus.data_out, 8'h00);
                chk("rst_reg_oe", bus.data_oe, 1);
                tick();
            end
        rd_off();
        tick();

        // channel 0: memory, no wait states
        wr(0, 0, 8'h01); wr(0, 1, 8'h3F); wr(0, 2, 8'h3C);
        bus.addr = 16'hF000; bus.strobe = 1;
        tick();
        chk("c0_sel", bus.selectout, 4'b0001);
        chk("c0_rdy_early", bus.ready, 0);
        tick();
        chk("c0_rdy", bus.ready, 1);
        bus.strobe = 0;
        tick();
        chk("c0_sel_off", bus.selectout, 0);
        chk("c0_rdy_off", bus.ready, 0);

        // channel 2: io, four wait states; a mid-cycle write must not shorten it
        wr(2, 0, 8'h13); wr(2, 1, 8'h3F); wr(2, 2, 8'h05);
        bus.addr = 16'h0014; bus.strobe = 1;
        tick();
        chk("c2_sel", bus.selectout, 4'b0100);
        wr(2, 0, 8'h03);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("c2_rdy_wait", bus.ready, 0);
        end
        tick();
        chk("c2_rdy", bus.ready, 1);
        chk("c2_sel_hold", bus.selectout, 4'b0100);
        bus.strobe = 0;
        tick();

        // channels 1 and 3 both match: lowest wins, conflict flagged then cleared by read
        wr(1, 0, 8'h01); wr(1, 1, 8'h3F); wr(1, 2, 8'h20);
        wr(3, 0, 8'h01); wr(3, 1, 8'h3F); wr(3, 2, 8'h20);
        bus.addr = 16'h8000; bus.strobe = 1;
        tick();
        chk("conf_sel", bus.selectout, 4'b0010);
        rd_set(3, 3);
        chk("conf_stat", bus.data_out, 8'h41);
        tick();
        chk("conf_clr", bus.data_out, 8'h01);
        rd_off();
        bus.strobe = 0;
        tick();

        // no channel matches
        bus.addr = 16'h0000; bus.strobe = 1;
        tick();
        chk("miss_sel", bus.selectout, 0);
        tick();
        chk("miss_rdy", bus.ready, 1);
        rd_set(0, 3);
        chk("miss_stat", bus.data_out, 8'h81);
        bus.strobe = 0;
        tick();
        rd_off();

        rd_set(0, 0);
`ifdef SELECTN_READBACK_EN
        chk("ctrl_rb", bus.data_out, 8'h01);
`else
        chk("ctrl_rb", bus.data_out, 8'h00);
`endif
        rd_off();
        tick();

        // reset in the middle of a waited cycle
        wr(2, 0, 8'h13);
        bus.addr = 16'h0014; bus.strobe = 1;
        tick();
        tick();
        chk("abort_sel_pre", bus.selectout, 4'b0100);
        rst = 1'b1;
        tick();
        chk("abort_sel", bus.selectout, 0);
        chk("abort_rdy", bus.ready, 0);
        rst = 1'b0;
        bus.strobe = 0;
        tick();

        // randomized traffic
        hold = 0;
        gap = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (bus.strobe) begin
                if (hold == 0) begin
                    bus.strobe = 0;
                    gap = $urandom_range(0, 2);
                end else hold--;
            end else if (gap > 0) gap--;
            else if ($urandom_range(0, 2) == 0) begin
                bus.strobe = 1;
                hold = $urandom_range(0, 10);
                bus.addr = rnd_addr();
            end
            bus.write = 0;
            bus.read = 0;
            bus.selectin = ($urandom_range(0, 3) != 0);
            bus.reg_addr = 4'($urandom);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                bus.write = 1;
                case (bus.reg_addr[1:0])
                    2'd1:    bus.data_in = mopts[$urandom_range(0, 3)] | (8'($urandom) & 8'hC0);
                    2'd2:    bus.data_in = 8'($urandom_range(0, 3));
                    default: bus.data_in = 8'($urandom);
                endcase
            end else if (op == 1) begin
                bus.read = 1;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        bus.strobe = 0;
        rd_off();
        bus.write = 0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
